multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle reduced RISC-V datapath.
- Executes a small RV32I subset through a fetch/decode/execute/memory/writeback state machine.
- Talks to instruction and data memories over req/ack handshakes, so variable-latency memories are tolerated.
- Exposes a0 (x10) for test benches and a halted/illegal status.

---
 rtl/multicycle_core.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core (ADD/SUB/ADDI/LW/SW/BEQ/BNE/JAL/EBREAK); 3-5 cycles per instruction with zero-wait memories.
// Memories are req/ack: a request is held with stable address/data until ack, so any memory latency is absorbed.
module multicycle_core #(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ack,
    output logic [WIDTH-1:0] a0,
    output logic             halted,
    output logic             illegal
);

    localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int A0_IDX = 10 % NREGS;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {K_ADD, K_SUB, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_JAL} kind_t;

    state_t           state_q;
    kind_t            kind_q;
    kind_t            kind_d;
    logic [31:0]      instr_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] result_q;
    logic [AW-1:0]    rd_q;
    logic             imem_req_q;
    logic             dmem_req_q;
    logic             dmem_we_q;
    logic [WIDTH-1:0] dmem_addr_q;
    logic [WIDTH-1:0] dmem_wdata_q;
    logic             halted_q;
    logic             illegal_q;
    logic [WIDTH-1:0] rf_q [NREGS];

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [AW-1:0]    rs1_idx;
    logic [AW-1:0]    rs2_idx;
    logic [AW-1:0]    rd_idx;
    logic [31:0]      imm32;
    logic [WIDTH-1:0] imm_d;
    logic             illegal_d;
    logic             ebreak_d;
    logic [WIDTH-1:0] pc_plus4;
    logic             taken;

    assign opcode   = instr_q[6:0];
    assign funct3   = instr_q[14:12];
    assign funct7   = instr_q[31:25];
    assign rs1_idx  = instr_q[15 +: AW];
    assign rs2_idx  = instr_q[20 +: AW];
    assign rd_idx   = instr_q[7 +: AW];
    assign imm_d    = WIDTH'($signed(imm32));
    assign pc_plus4 = pc_q + WIDTH'(4);
    assign taken    = (kind_q == K_BEQ) ? (opa_q == opb_q) : (opa_q != opb_q);

    always_comb begin
        kind_d    = K_ADD;
        illegal_d = 1'b0;
        ebreak_d  = 1'b0;
        imm32     = '0;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000)      kind_d = K_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) kind_d = K_SUB;
                else                                                illegal_d = 1'b1;
            end
            7'b0010011: begin
                imm32     = {{20{instr_q[31]}}, instr_q[31:20]};
                kind_d    = K_ADDI;
                illegal_d = (funct3 != 3'b000);
            end
            7'b0000011: begin
                imm32     = {{20{instr_q[31]}}, instr_q[31:20]};
                kind_d    = K_LW;
                illegal_d = (funct3 != 3'b010);
            end
            7'b0100011: begin
                imm32     = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
                kind_d    = K_SW;
                illegal_d = (funct3 != 3'b010);
            end
            7'b1100011: begin
                imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                         instr_q[11:8], 1'b0};
                if (funct3 == 3'b000)      kind_d = K_BEQ;
                else if (funct3 == 3'b001) kind_d = K_BNE;
                else                       illegal_d = 1'b1;
            end
            7'b1101111: begin
                imm32  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                          instr_q[30:21], 1'b0};
                kind_d = K_JAL;
            end
            7'b1110011: begin
                if (instr_q == 32'h0010_0073) ebreak_d  = 1'b1;
                else                          illegal_d = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            kind_q       <= K_ADD;
            instr_q      <= '0;
            pc_q         <= RESET_PC;
            opa_q        <= '0;
            opb_q        <= '0;
            imm_q        <= '0;
            result_q     <= '0;
            rd_q         <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                // The first cycle out of reset only raises the request; ack counts once req is visible.
                S_FETCH: begin
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa_q  <= rf_q[rs1_idx];
                    opb_q  <= rf_q[rs2_idx];
                    imm_q  <= imm_d;
                    kind_q <= kind_d;
                    rd_q   <= rd_idx;
                    if (illegal_d) begin
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else if (ebreak_d) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (kind_q)
                        K_ADD:  begin result_q <= opa_q + opb_q; state_q <= S_WB; end
                        K_SUB:  begin result_q <= opa_q - opb_q; state_q <= S_WB; end
                        K_ADDI: begin result_q <= opa_q + imm_q; state_q <= S_WB; end
                        K_LW, K_SW: begin
                            dmem_addr_q  <= opa_q + imm_q;
                            dmem_wdata_q <= opb_q;
                            dmem_we_q    <= (kind_q == K_SW);
                            dmem_req_q   <= 1'b1;
                            state_q      <= S_MEM;
                        end
                        K_BEQ, K_BNE: begin
                            pc_q       <= taken ? (pc_q + imm_q) : pc_plus4;
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                        K_JAL: begin
                            result_q <= pc_plus4;
                            pc_q     <= pc_q + imm_q;
                            state_q  <= S_WB;
                        end
                        default: state_q <= S_HALT;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (kind_q == K_LW) begin
                            result_q <= dmem_rdata;
                            state_q  <= S_WB;
                        end else begin
                            pc_q       <= pc_plus4;
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (rd_q != '0) rf_q[rd_q] <= result_q;
                    if (kind_q != K_JAL) pc_q <= pc_plus4;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_HALT: ;
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign a0         = rf_q[A0_IDX];
    assign halted     = halted_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: behavioural imem/dmem with programmable data wait states and a fetch log.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, a0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          dmem_wait = 0;
    bit          dmem_hold = 1'b0;
    int          dcnt     = 0;
    bit          prev_req = 1'b0;
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] log_addr [$];
    int          log_cyc  [$];
    logic [31:0] log_a0   [$];

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    multicycle_core #(.WIDTH(32), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .a0(a0), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_rdata = dmem[dmem_addr[7:2]];

    // Memory models answer on the falling edge; the core samples ack on the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            dcnt     = 0;
            prev_req = 1'b0;
        end else begin
            imem_ack = imem_req;
            if (imem_req && !prev_req) begin
                log_addr.push_back(imem_addr);
                log_cyc.push_back(cyc);
                log_a0.push_back(a0);
            end
            prev_req = imem_req;
            if (!dmem_req || dmem_hold) begin
                dmem_ack = 1'b0;
                dcnt     = 0;
            end else if (dcnt == dmem_wait) begin
                dmem_ack = 1'b1;
                if (dmem_we) dmem[dmem_addr[7:2]] = dmem_wdata;
            end else begin
                dcnt++;
                dmem_ack = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b0;
        dmem_wait = 0;
        dmem_hold = 1'b0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = EBREAK;
            dmem[i] = '0;
        end
        log_addr.delete();
        log_cyc.delete();
        log_a0.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run_until_halt(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_req: got %b want 0", dmem_req); end
        n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_we: got %b want 0", dmem_we); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL reset_a0: got %h want 0", a0); end
        n_checks++; if (dmem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_dmem_addr: got %h want 0", dmem_addr); end
        n_checks++; if (dmem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_dmem_wdata: got %h want 0", dmem_wdata); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", imem_addr); end
    endtask

    task automatic test_addi_latency();
        bit found = 1'b0;
        bit ok;
        do_reset();
        imem[0] = 32'h0050_0513;                          // addi x10,x0,5
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL addi_first_fetch: got %b want 1", found); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL addi_fetch_addr: got %h want 0", imem_addr); end
        repeat (3) @(negedge clk);
        n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL addi_edge3_a0: got %h want 0", a0); end
        @(negedge clk);
        n_checks++; if (a0 !== 32'h5) begin n_fail++; $display("FAIL addi_edge4_a0: got %h want 5", a0); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL addi_next_pc: got %h want 4", imem_addr); end
        run_until_halt(50, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL addi_halt_timeout: got %b want 1", ok); end
    endtask

    task automatic test_loop();
        logic [31:0] exp_addr [10] = '{32'h0, 32'h40, 32'h44, 32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h4, 32'h8};
        logic [31:0] exp_a0   [10] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3};
        int          exp_dt   [9]  = '{4, 4, 4, 4, 3, 4, 3, 4, 3};
        bit found = 1'b0;
        bit ok;
        int n;
        do_reset();
        // Reset entry jumps to a setup block that loads x5=3, then returns to 0x0,
        // which is rewritten to the loop body once the setup block is reached.
        imem[0]  = 32'h0400_006F;                         // jal x0,+0x40
        imem[1]  = 32'hFE55_1EE3;                         // bne x10,x5,-4
        imem[16] = 32'h0030_0293;                         // addi x5,x0,3
        imem[17] = 32'hFBDF_F06F;                         // jal x0,-0x44
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h40) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL loop_setup_fetch: got %b want 1", found); end
        imem[0] = 32'h0015_0513;                          // addi x10,x10,1
        run_until_halt(300, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL loop_halt_timeout: got %b want 1", ok); end
        n_checks++; if (log_addr.size() !== 10) begin n_fail++; $display("FAIL loop_fetch_count: got %0d want 10", log_addr.size()); end
        n = (log_addr.size() < 10) ? log_addr.size() : 10;
        for (int i = 0; i < n; i++) begin
            n_checks++; if (log_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL loop_pc[%0d]: got %h want %h", i, log_addr[i], exp_addr[i]); end
            n_checks++; if (log_a0[i] !== exp_a0[i]) begin n_fail++; $display("FAIL loop_a0[%0d]: got %h want %h", i, log_a0[i], exp_a0[i]); end
            if (i > 0) begin
                n_checks++; if (log_cyc[i] - log_cyc[i-1] !== exp_dt[i-1]) begin n_fail++; $display("FAIL loop_cycles[%0d]: got %0d want %0d", i-1, log_cyc[i] - log_cyc[i-1], exp_dt[i-1]); end
            end
        end
        n_checks++; if (a0 !== 32'h3) begin n_fail++; $display("FAIL loop_final_a0: got %h want 3", a0); end
    endtask

    task automatic test_mem_wait();
        logic [31:0] exp_addr [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        int          exp_dt   [5] = '{4, 6, 4, 7, 4};
        int st_cyc = 0;
        int ld_cyc = 0;
        bit ok = 1'b0;
        int n;
        do_reset();
        imem[0] = 32'h5A50_0513;                          // addi x10,x0,0x5a5
        imem[1] = 32'h00A0_2423;                          // sw   x10,8(x0)
        imem[2] = 32'h0000_0513;                          // addi x10,x0,0
        imem[3] = 32'h0080_2583;                          // lw   x11,8(x0)
        imem[4] = 32'h0005_8533;                          // add  x10,x11,x0
        dmem_wait = 2;
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dmem_req) begin
                n_checks++; if (dmem_addr !== 32'h8) begin n_fail++; $display("FAIL mem_addr_stable: got %h want 8", dmem_addr); end
                if (dmem_we) begin
                    st_cyc++;
                    n_checks++; if (dmem_wdata !== 32'h5A5) begin n_fail++; $display("FAIL mem_wdata_stable: got %h want 5a5", dmem_wdata); end
                end else begin
                    ld_cyc++;
                end
            end
            if (halted) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mem_halt_timeout: got %b want 1", ok); end
        n_checks++; if (st_cyc !== 3) begin n_fail++; $display("FAIL mem_store_req_cycles: got %0d want 3", st_cyc); end
        n_checks++; if (ld_cyc !== 3) begin n_fail++; $display("FAIL mem_load_req_cycles: got %0d want 3", ld_cyc); end
        n_checks++; if (dmem[2] !== 32'h5A5) begin n_fail++; $display("FAIL mem_stored_word: got %h want 5a5", dmem[2]); end
        n_checks++; if (a0 !== 32'h5A5) begin n_fail++; $display("FAIL mem_loaded_x11: got %h want 5a5", a0); end
        n_checks++; if (log_addr.size() !== 6) begin n_fail++; $display("FAIL mem_fetch_count: got %0d want 6", log_addr.size()); end
        n = (log_addr.size() < 6) ? log_addr.size() : 6;
        for (int i = 0; i < n; i++) begin
            n_checks++; if (log_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL mem_pc[%0d]: got %h want %h", i, log_addr[i], exp_addr[i]); end
            if (i > 0) begin
                n_checks++; if (log_cyc[i] - log_cyc[i-1] !== exp_dt[i-1]) begin n_fail++; $display("FAIL mem_cycles[%0d]: got %0d want %0d", i-1, log_cyc[i] - log_cyc[i-1], exp_dt[i-1]); end
            end
        end
    endtask

    task automatic test_x0_and_beq();
        logic [31:0] exp_addr [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h14};
        bit ok;
        int n;
        do_reset();
        imem[0] = 32'h0090_0513;                          // addi x10,x0,9
        imem[1] = 32'h0070_0013;                          // addi x0,x0,7
        imem[2] = 32'h0000_0533;                          // add  x10,x0,x0
        imem[3] = 32'h0005_0463;                          // beq  x10,x0,+8
        imem[4] = 32'h0010_0513;                          // addi x10,x0,1 (skipped)
        rst = 1'b1;
        run_until_halt(100, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL x0_halt_timeout: got %b want 1", ok); end
        n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL x0_write_discarded: got %h want 0", a0); end
        n_checks++; if (log_addr.size() !== 5) begin n_fail++; $display("FAIL x0_fetch_count: got %0d want 5", log_addr.size()); end
        n = (log_addr.size() < 5) ? log_addr.size() : 5;
        for (int i = 0; i < n; i++) begin
            n_checks++; if (log_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL x0_pc[%0d]: got %h want %h", i, log_addr[i], exp_addr[i]); end
        end
        if (n == 5) begin
            n_checks++; if (log_a0[2] !== 32'h9) begin n_fail++; $display("FAIL x0_a0_before_add: got %h want 9", log_a0[2]); end
            n_checks++; if (log_cyc[4] - log_cyc[3] !== 3) begin n_fail++; $display("FAIL beq_taken_cycles: got %0d want 3", log_cyc[4] - log_cyc[3]); end
        end
    endtask

    task automatic test_illegal_ebreak();
        bit found = 1'b0;
        bit ok;
        do_reset();
        imem[0] = 32'h0000_007F;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL ill_first_fetch: got %b want 1", found); end
        @(negedge clk);
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL ill_halted_early: got %b want 0", halted); end
        @(negedge clk);
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ill_halted: got %b want 1", halted); end
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b want 1", illegal); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++; if ({imem_req, dmem_req} !== 2'b00) begin n_fail++; $display("FAIL ill_no_requests: got %b want 00", {imem_req, dmem_req}); end
        end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ill_halt_sticky: got %b want 1", halted); end

        do_reset();
        rst = 1'b1;
        run_until_halt(20, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ebreak_halt_timeout: got %b want 1", ok); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ebreak_illegal: got %b want 0", illegal); end
    endtask

    task automatic test_reset_mid_mem();
        bit found = 1'b0;
        bit ok;
        do_reset();
        imem[0] = 32'h0770_0513;                          // addi x10,x0,0x77
        imem[1] = 32'h00A0_2023;                          // sw   x10,0(x0)
        dmem_hold = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dmem_req) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_mem_req: got %b want 1", found); end
        n_checks++; if (a0 !== 32'h77) begin n_fail++; $display("FAIL rmid_a0_before: got %h want 77", a0); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_async_drop: got %b want 0", dmem_req); end
        n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we_async_drop: got %b want 0", dmem_we); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_pc_reset: got %h want 0", imem_addr); end
        n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL rmid_a0_cleared: got %h want 0", a0); end
        @(negedge clk);
        dmem_hold = 1'b0;
        imem[0] = 32'h00A0_2223;                          // sw x10,4(x0)
        imem[1] = EBREAK;
        dmem[1] = 32'hDEAD_BEEF;
        log_addr.delete();
        log_cyc.delete();
        log_a0.delete();
        rst = 1'b1;
        run_until_halt(50, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_halt_timeout: got %b want 1", ok); end
        n_checks++; if (dmem[1] !== 32'h0) begin n_fail++; $display("FAIL rmid_x10_zero_store: got %h want 0", dmem[1]); end
        n_checks++; if (dmem[0] !== 32'h0) begin n_fail++; $display("FAIL rmid_abandoned_store: got %h want 0", dmem[0]); end
        if (log_addr.size() > 0) begin
            n_checks++; if (log_addr[0] !== 32'h0) begin n_fail++; $display("FAIL rmid_first_fetch_pc: got %h want 0", log_addr[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_addi_latency();
        test_loop();
        test_mem_wait();
        test_x0_and_beq();
        test_illegal_ebreak();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
